// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file and its writeback path.
package grf_pkg;

  localparam int unsigned GRF_REG_NUM = 32;
  localparam int unsigned GRF_AW      = 5;
  localparam int unsigned GRF_DW      = 32;
  localparam int unsigned GRF_PC_W    = 32;

  localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;

  // Writeback selector codes, shared so decoder and writeback mux agree.
  typedef enum logic [2:0] {
    WB_SEL_ALU    = 3'b000,
    WB_SEL_MDU    = 3'b001,
    WB_SEL_BRIDGE = 3'b010,
    WB_SEL_PC8    = 3'b011,
    WB_SEL_CP0    = 3'b100
  } wb_sel_e;

  typedef struct packed {
    logic [GRF_PC_W-1:0] pc;
    logic [GRF_AW-1:0]   addr;
    logic [GRF_DW-1:0]   data;
  } trace_rec_t;

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port: $0 masking plus optional same-cycle write forwarding.
// Forwarding is compiled in when GRF_BYPASS_EN is defined.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int unsigned REG_NUM = GRF_REG_NUM,
  parameter int unsigned DW      = GRF_DW
) (
  input  logic [GRF_AW-1:0] addr,
  input  logic [DW-1:0]     regs [REG_NUM],
  input  logic              wr_en,
  input  logic [GRF_AW-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic [DW-1:0]     rdata_c
);

`ifdef GRF_BYPASS_EN
  always_comb begin
    rdata_c = '0;
    if (addr != REG_ZERO) begin
      rdata_c = regs[addr];
      if (wr_en && (wr_addr == addr)) rdata_c = wr_data;
    end
  end
`else
  logic unused_wr_c;
  assign unused_wr_c = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    rdata_c = '0;
    if (addr != REG_ZERO) rdata_c = regs[addr];
  end
`endif

endmodule

// File: rtl/grf_regfile.sv
// 32x32 MIPS register file: one write port, two async read ports, registered write trace.
// Define GRF_BYPASS_EN to forward the W-stage write to both readers in the same cycle.
module grf_regfile
  import grf_pkg::*;
#(
  parameter int unsigned REG_NUM = GRF_REG_NUM,
  parameter int unsigned DW      = GRF_DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                WE,
  input  logic [GRF_AW-1:0]   A1,
  input  logic [GRF_AW-1:0]   A2,
  input  logic [GRF_AW-1:0]   A3,
  input  logic [DW-1:0]       WD,
  input  logic [GRF_PC_W-1:0] pc,
  output logic [DW-1:0]       RD1,
  output logic [DW-1:0]       RD2,
  output logic                trace_valid,
  output logic [GRF_PC_W-1:0] trace_pc,
  output logic [GRF_AW-1:0]   trace_addr,
  output logic [GRF_DW-1:0]   trace_data,
  output logic [31:0]         wr_count
);

  logic [DW-1:0] regs_q [REG_NUM];
  logic [DW-1:0] regs_d [REG_NUM];
  trace_rec_t    trace_q, trace_d;
  logic          trace_valid_q, trace_valid_d;
  logic [31:0]   wr_count_q, wr_count_d;
  logic          commit_c;

  // Writes to $0 are dropped entirely: no storage, no trace, no count.
  always_comb begin
    commit_c      = WE && (A3 != REG_ZERO);
    regs_d        = regs_q;
    trace_d       = trace_q;
    trace_valid_d = commit_c;
    wr_count_d    = wr_count_q;
    if (commit_c) begin
      regs_d[A3]   = WD;
      trace_d.pc   = pc;
      trace_d.addr = A3;
      trace_d.data = GRF_DW'(WD);
      wr_count_d   = wr_count_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q        <= '{default: '0};
      trace_q       <= '0;
      trace_valid_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      regs_q        <= regs_d;
      trace_q       <= trace_d;
      trace_valid_q <= trace_valid_d;
      wr_count_q    <= wr_count_d;
    end
  end

  grf_read_port #(.REG_NUM(REG_NUM), .DW(DW)) u_rd1 (
    .addr    (A1),
    .regs    (regs_q),
    .wr_en   (WE),
    .wr_addr (A3),
    .wr_data (WD),
    .rdata_c (RD1)
  );

  grf_read_port #(.REG_NUM(REG_NUM), .DW(DW)) u_rd2 (
    .addr    (A2),
    .regs    (regs_q),
    .wr_en   (WE),
    .wr_addr (A3),
    .wr_data (WD),
    .rdata_c (RD2)
  );

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_q.pc;
  assign trace_addr  = trace_q.addr;
  assign trace_data  = trace_q.data;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_grf_regfile.sv
// Self-checking bench for grf_regfile: directed scenarios plus random traffic against an array model.
module tb_grf_regfile;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, pc;
  logic [31:0] RD1, RD2;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [31:0] wr_count;

  int n_vec = 0;
  int n_err = 0;

`ifdef GRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Architectural model: register array, write counter and last trace record.
  logic [31:0] mem [32];
  logic [31:0] m_cnt, m_tpc, m_tdata;
  logic [4:0]  m_taddr;
  logic        m_tv;

  grf_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .WE          (WE),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .WD          (WD),
    .pc          (pc),
    .RD1         (RD1),
    .RD2         (RD2),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && WE && (A3 == a)) return WD;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    m_cnt = 0; m_tv = 0; m_tpc = 0; m_taddr = 0; m_tdata = 0;
  endtask

  task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] p);
    WE = we; A1 = a1; A2 = a2; A3 = a3; WD = wd; pc = p;
    #1;
  endtask

  // Advance one rising edge and apply the architectural effect of the presented write.
  task automatic edge_step();
    @(posedge clk);
    if (!reset) begin
      if (WE && A3 != 5'd0) begin
        mem[A3] = WD; m_tv = 1'b1; m_tpc = pc; m_taddr = A3; m_tdata = WD;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_tv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(1'b0, 5'd5, 5'd31, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL reset_rd1: got %h want 0", RD1); end
    n_vec++; if (RD2 !== 32'd0) begin n_err++; $display("FAIL reset_rd2: got %h want 0", RD2); end
    n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_tv: got %b want 0", trace_valid); end
    n_vec++; if (wr_count !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", wr_count); end
    n_vec++; if ({trace_pc, trace_addr, trace_data} !== 69'd0) begin
      n_err++; $display("FAIL reset_trace: got pc %h addr %0d data %h want zeros", trace_pc, trace_addr, trace_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 32'h1234_5678, 32'h0000_3000);
    edge_step();
    drive(1'b0, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'h1234_5678) begin n_err++; $display("FAIL wr_rd1: got %h want 12345678", RD1); end
    n_vec++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL wr_tv: got %b want 1", trace_valid); end
    n_vec++; if (trace_pc !== 32'h3000) begin n_err++; $display("FAIL wr_tpc: got %h want 3000", trace_pc); end
    n_vec++; if (trace_addr !== 5'd8) begin n_err++; $display("FAIL wr_taddr: got %0d want 8", trace_addr); end
    n_vec++; if (trace_data !== 32'h1234_5678) begin n_err++; $display("FAIL wr_tdata: got %h want 12345678", trace_data); end
    n_vec++; if (wr_count !== 32'd1) begin n_err++; $display("FAIL wr_cnt: got %0d want 1", wr_count); end
  endtask

  task automatic test_zero_write();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
    n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL zero_rd_same: got %h want 0", RD1); end
    edge_step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL zero_rd_after: got %h want 0", RD1); end
    n_vec++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL zero_tv: got %b want 0", trace_valid); end
    n_vec++; if (wr_count !== 32'd1) begin n_err++; $display("FAIL zero_cnt: got %0d want 1", wr_count); end
    n_vec++; if (trace_addr !== 5'd8) begin n_err++; $display("FAIL zero_taddr_hold: got %0d want 8", trace_addr); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_0001, 32'h0000_3008);
    edge_step();
    drive(1'b1, 5'd9, 5'd9, 5'd9, 32'hAAAA_5555, 32'h0000_300C);
    want = BYPASS ? 32'hAAAA_5555 : 32'h0000_0001;
    n_vec++; if (RD1 !== want) begin n_err++; $display("FAIL same_rd1: got %h want %h", RD1, want); end
    n_vec++; if (RD2 !== want) begin n_err++; $display("FAIL same_rd2: got %h want %h", RD2, want); end
    edge_step();
    drive(1'b0, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'hAAAA_5555) begin n_err++; $display("FAIL same_after: got %h want aaaa5555", RD1); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #2;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'(i), 32'(i * 17), 32'(32'h3100 + 4 * i));
      edge_step();
      n_vec++; if (trace_valid !== 1'b1 || trace_addr !== 5'(i) || trace_data !== 32'(i * 17)
                   || trace_pc !== 32'(32'h3100 + 4 * i)) begin
        n_err++; $display("FAIL b2b_trace%0d: got v%b pc %h addr %0d data %h want v1 pc %h addr %0d data %h",
                          i, trace_valid, trace_pc, trace_addr, trace_data, 32'(32'h3100 + 4 * i), i, 32'(i * 17));
      end
    end
    drive(1'b0, 5'd2, 5'd3, 5'd0, 32'd0, 32'd0);
    n_vec++; if (wr_count !== 32'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", wr_count); end
    n_vec++; if (RD1 !== 32'h22 || RD2 !== 32'h33) begin
      n_err++; $display("FAIL b2b_rd: got %h %h want 22 33", RD1, RD2);
    end
    edge_step();
    n_vec++; if (trace_valid !== 1'b0 || trace_data !== 32'h33) begin
      n_err++; $display("FAIL b2b_idle: got v%b data %h want v0 data 33", trace_valid, trace_data);
    end
  endtask

  task automatic test_random();
    logic [4:0] a1, a2, a3;
    for (int n = 0; n < 400; n++) begin
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), a1, a2, a3, $urandom, $urandom);
      n_vec++; if (RD1 !== exp_rd(A1)) begin n_err++; $display("FAIL rand_rd1 #%0d: A1=%0d got %h want %h", n, A1, RD1, exp_rd(A1)); end
      n_vec++; if (RD2 !== exp_rd(A2)) begin n_err++; $display("FAIL rand_rd2 #%0d: A2=%0d got %h want %h", n, A2, RD2, exp_rd(A2)); end
      edge_step();
      n_vec++; if (trace_valid !== m_tv || trace_pc !== m_tpc || trace_addr !== m_taddr || trace_data !== m_tdata) begin
        n_err++; $display("FAIL rand_trace #%0d: got v%b pc %h addr %0d data %h want v%b pc %h addr %0d data %h",
                          n, trace_valid, trace_pc, trace_addr, trace_data, m_tv, m_tpc, m_taddr, m_tdata);
      end
      n_vec++; if (wr_count !== m_cnt) begin n_err++; $display("FAIL rand_cnt #%0d: got %0d want %0d", n, wr_count, m_cnt); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 32'h44, 32'h3200);
    edge_step();
    drive(1'b1, 5'd4, 5'd0, 5'd4, 32'h55, 32'h3204);
    n_vec++; if (RD1 !== exp_rd(5'd4)) begin n_err++; $display("FAIL ar_pre: got %h want %h", RD1, exp_rd(5'd4)); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++; if (trace_valid !== 1'b0 || {trace_pc, trace_addr, trace_data} !== 69'd0) begin
      n_err++; $display("FAIL ar_trace: got v%b pc %h addr %0d data %h want zeros", trace_valid, trace_pc, trace_addr, trace_data);
    end
    n_vec++; if (wr_count !== 32'd0) begin n_err++; $display("FAIL ar_cnt: got %0d want 0", wr_count); end
    drive(1'b0, 5'd4, 5'd4, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL ar_rd_now: got %h want 0", RD1); end
    drive(1'b1, 5'd0, 5'd0, 5'd4, 32'h77, 32'h3208);
    edge_step();
    drive(1'b0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0);
    n_vec++; if (RD1 !== 32'd0 || trace_valid !== 1'b0 || wr_count !== 32'd0) begin
      n_err++; $display("FAIL ar_held: got rd %h v%b cnt %0d want 0 0 0", RD1, trace_valid, wr_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_write();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/grf_regfile.md
# grf_regfile

General-purpose register file of the pipelined MIPS CPU: 32 × 32-bit registers with one write port fed by the W-stage write-data selector and two asynchronous read ports serving the D stage. It is the consumer end of the writeback path. It stores the selected write data, enforces the hard-wired `$0`, and optionally forwards same-cycle writes to the readers. It also emits a registered write-trace record used by the grading testbench to check every architectural register update.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers.
- `DW`, 32: data width.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `WE` in 1: write enable from W stage.
- `A1` in 5: read address, port 1.
- `A2` in 5: read address, port 2.
- `A3` in 5: write address.
- `WD` in 32: write data from the writeback selector.
- `pc` in 32: PC of the W-stage instruction; used for trace only.
- `RD1` out 32: read data, port 1.
- `RD2` out 32: read data, port 2.
- `trace_valid` out 1: one-cycle pulse marking a committed write record.
- `trace_pc` out 32: PC of the logged write.
- `trace_addr` out 5: destination register of the logged write.
- `trace_data` out 32: value written.
- `wr_count` out 32: number of committed writes since reset.

## Operation
- Storage is `REG_NUM` registers. Register 0 always reads 0 and is never modified.
- A write commits on the rising edge when `WE=1` and `A3!=0`. The stored value is `WD`. With `WE=1` and `A3=0` nothing is stored and nothing is logged.
- Reads are combinational.
  - `RDx = (Ax==0) ? 0 : reg[Ax]`.
  - If the bypass is enabled (see Configuration), the bypass value overrides this.
- Trace: on each committed write, the next edge registers `trace_valid=1`, `trace_pc=pc`, `trace_addr=A3` and `trace_data=WD`.
  - `trace_valid` returns to 0 on the next edge without a committed write.
  - `trace_pc`, `trace_addr` and `trace_data` hold their last values while `trace_valid=0`.
- `wr_count` increments by 1 per committed write and wraps from 0xFFFFFFFF to 0.
- Simultaneous events:
  - Read and write of the same nonzero register in the same cycle: the read returns the new value if the bypass is enabled, otherwise the old value.
  - Both ports reading the same address is permitted and returns identical data.
- Reset: while `reset=1`, all registers, `trace_*` and `wr_count` are 0, and any write presented in that cycle is discarded. Reset asserted mid-write, asynchronously between edges, clears immediately and no record is emitted.

## Timing
- Write latency: value visible on the RD ports in the cycle after the write edge. With the bypass enabled, it is visible in the same cycle, combinationally.
- Trace latency: exactly 1 cycle after the commit edge. `trace_valid` is asserted the cycle following the write.
- No handshake; the W stage never stalls the register file.
- Reset values: `RD1`/`RD2`=0 (all registers 0), `trace_valid`=0, `trace_pc`=0, `trace_addr`=0, `trace_data`=0, `wr_count`=0.

## Configuration
- `GRF_BYPASS_EN` defined: internal write-to-read forwarding.
  - `RDx = WD` when `WE=1`, `A3!=0` and `Ax==A3`.
  - Removes the need for a D-stage forward from W.
- Undefined: no internal forwarding. Reads return only stored values, and the pipeline must forward from W externally.

## Structure
- Shared package holds:
  - `REG_NUM`, the 5-bit register address width and `DW`.
  - The constant `REG_ZERO = 5'd0`.
  - The writeback selector codes: ALU 3'b000, MDU 3'b001, bridge 3'b010, PC+8 3'b011, CP0 3'b100. These are kept alongside so decoder and writeback agree.
- One natural sub-module: `grf_read_port` (address → data, with `$0` masking and the optional bypass), instantiated twice.

## Test plan
- Reset, then read `A1=5`, `A2=31`: `RD1=RD2=0`, `trace_valid=0`, `wr_count=0`.
- Write `A3=8`, `WD=0x12345678`, `pc=0x3000` for one cycle, then read `A1=8`:
  - `RD1=0x12345678`.
  - Next cycle has `trace_valid=1`, `trace_pc=0x3000`, `trace_addr=8`, `trace_data=0x12345678`.
  - `wr_count=1`.
- Write `A3=0`, `WD=0xFFFFFFFF`: `RD1` at `A1=0` stays 0, no trace pulse, `wr_count` unchanged.
- Same-cycle `A1=A3=9`, `WD=0xAAAA5555`, with reg9 previously 0x1: `RD1=0xAAAA5555` with `GRF_BYPASS_EN`, `RD1=0x1` without it.
- Back-to-back writes to regs 1, 2, 3 with values 0x11, 0x22, 0x33: three consecutive trace pulses in order, `wr_count=3`.
- Assert `reset` mid-cycle after writing reg4=0x44: reg4 reads 0 immediately, and all `trace_*` and `wr_count` are 0.
